servo_pwm: RTL
==============

// Module: servo_pwm
// PURPOSE
//  Turns the rate-limited servo angle produced by the angle ramp block into the hobby-servo
//  PWM waveform: one pulse per fixed frame, pulse width linear in angle (0..180 deg).
//  Sits between the angle ramp output and the servo pin. The angle is sampled only at frame
//  boundaries, so a mid-frame angle change never produces a runt or stretched pulse.
// PARAMETERS
//  PERIOD_CYCLES  1000000  frame length in clk cycles (20 ms @ 50 MHz); < 2^20
//  MIN_PULSE      50000    pulse width at 0 deg, in clk cycles (1 ms @ 50 MHz)
//  TICKS_PER_DEG  278      extra pulse cycles per degree; 180 deg -> 100040 cycles
//  MAX_ANGLE      180      clamp limit applied to the angle input
// PORTS
//  clk          in   1   system clock
//  rst          in   1   asynchronous, active-low reset
//  enable       in   1   run request; sampled only at frame boundaries
//  angle        in   8   target angle in degrees (from ramp block out_angle)
//  pwm          out  1   servo drive pulse, registered
//  frame_start  out  1   1-cycle strobe, high in the first cycle of every frame
//  cur_angle    out  8   clamped angle latched for the frame in progress
//  running      out  1   high while state is RUN
// BEHAVIOUR
//  - Reset (rst=0, async): state=IDLE, cnt=0, width=0, pwm=0, frame_start=0,
//    cur_angle=0, running=0. Takes effect immediately, even mid-pulse.
//  - Clamp: a = (angle > MAX_ANGLE) ? MAX_ANGLE : angle.
//    Width = MIN_PULSE + a*TICKS_PER_DEG, computed in 20 bits (no overflow at defaults).
//  - FSM states: IDLE, RUN.
//    IDLE: pwm=0, cnt held at 0. If enable=1 on a clk edge, the next cycle is frame cycle 0
//    (1-cycle latency from enable to the pwm rise).
//    RUN: cnt counts 0..PERIOD_CYCLES-1, then wraps to 0.
//  - Frame cycle 0:
//    frame_start=1; cur_angle<=a and width<=Width, both taken from the angle value present
//    on the edge that enters cycle 0.
//  - pwm=1 exactly in frame cycles 0..width-1, otherwise 0.
//    pwm and frame_start rise in the same cycle.
//  - Frame end (cnt=PERIOD_CYCLES-1):
//    enable=1 -> wrap to cycle 0 of a new frame; enable=0 -> IDLE, no further frame_start.
//    A frame already started always completes, even if enable drops mid-frame.
//  - Angle changes mid-frame are ignored until the next frame boundary.
//    cur_angle and width never change mid-frame.
//  - Simultaneous frame end and an angle change on the same edge: the new angle is used for
//    the new frame.
//  - Width >= PERIOD_CYCLES (misconfigured parameters): pwm stays high for the whole frame.
//    There is no extra frame.
//  - running=1 exactly while in RUN. All outputs are registered; no combinational input->output path.
// TESTING (sim params PERIOD_CYCLES=1000, MIN_PULSE=50, TICKS_PER_DEG=1)
//  1 Reset: rst=0 with enable=1, angle=90
//    -> pwm=0, frame_start=0, cur_angle=0, running=0 throughout.
//  2 Release rst, enable=1, angle=90
//    -> frame_start every 1000 cycles; pwm high 140 cycles per frame; cur_angle=90.
//  3 angle=200 -> cur_angle=180, pwm high 230 cycles.
//    angle=0 -> pwm high 50 cycles.
//  4 angle 0->180 at frame cycle 20 -> current frame pwm=50 cycles, next frame 230 cycles.
//    No runt pulse.
//  5 enable 1->0 at frame cycle 100 -> frame completes to cycle 999, then pwm=0 and running=0.
//    No frame_start. Re-enable -> frame_start 1 cycle later.
//  6 rst=0 at frame cycle 30 (pwm high) -> pwm=0 the same cycle, state IDLE.
//    Release with enable=1 -> fresh frame from cycle 0.

Source files
------------

// File: rtl/servo_pwm.sv
// Hobby-servo PWM generator: one pulse per fixed frame, with the pulse width linear in the
// clamped angle. The angle is latched only at frame boundaries, so pulses are never runts.
module servo_pwm #(
  parameter int PERIOD_CYCLES = 1000000,
  parameter int MIN_PULSE     = 50000,
  parameter int TICKS_PER_DEG = 278,
  parameter int MAX_ANGLE     = 180
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [7:0] angle,
  output logic       pwm,
  output logic       frame_start,
  output logic [7:0] cur_angle,
  output logic       running
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam logic [19:0] LAST_CYC = 20'(PERIOD_CYCLES - 1);
  localparam logic [7:0]  ANG_LIM  = 8'(MAX_ANGLE);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [19:0] r_cnt;
  logic [19:0] w_cnt_nxt;
  logic [19:0] r_width;
  logic [19:0] w_width_nxt;
  logic        r_pwm;
  logic        w_pwm_nxt;
  logic        r_frame_start;
  logic        w_frame_start_nxt;
  logic [7:0]  r_cur_angle;
  logic [7:0]  w_cur_angle_nxt;

  logic [7:0]  w_angle_clamped;
  logic [19:0] w_width_calc;
  logic        w_frame_end;
  logic        w_new_frame;

  assign w_angle_clamped = (angle > ANG_LIM) ? ANG_LIM : angle;
  assign w_width_calc    = 20'(MIN_PULSE) + 20'(w_angle_clamped) * 20'(TICKS_PER_DEG);

  // A new frame begins either from IDLE or straight out of the last cycle of a running frame.
  assign w_frame_end = (r_state == S_RUN) && (r_cnt == LAST_CYC);
  assign w_new_frame = enable && ((r_state == S_IDLE) || w_frame_end);

  always_comb begin
    w_state_nxt       = r_state;
    w_cnt_nxt         = r_cnt;
    w_width_nxt       = r_width;
    w_cur_angle_nxt   = r_cur_angle;
    w_frame_start_nxt = 1'b0;
    w_pwm_nxt         = 1'b0;
    if (w_new_frame) begin
      w_state_nxt       = S_RUN;
      w_cnt_nxt         = 20'd0;
      w_width_nxt       = w_width_calc;
      w_cur_angle_nxt   = w_angle_clamped;
      w_frame_start_nxt = 1'b1;
      w_pwm_nxt         = (w_width_calc != 20'd0);
    end else if (r_state == S_RUN) begin
      if (w_frame_end) begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 20'd0;
      end else begin
        w_cnt_nxt = r_cnt + 20'd1;
        // pwm in cycle n is (n < width); a width past the frame end keeps it high throughout.
        w_pwm_nxt = ((r_cnt + 20'd1) < r_width);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt         <= 20'd0;
      r_width       <= 20'd0;
      r_pwm         <= 1'b0;
      r_frame_start <= 1'b0;
      r_cur_angle   <= 8'd0;
    end else begin
      r_cnt         <= w_cnt_nxt;
      r_width       <= w_width_nxt;
      r_pwm         <= w_pwm_nxt;
      r_frame_start <= w_frame_start_nxt;
      r_cur_angle   <= w_cur_angle_nxt;
    end
  end

  assign pwm         = r_pwm;
  assign frame_start = r_frame_start;
  assign cur_angle   = r_cur_angle;
  assign running     = (r_state == S_RUN);

endmodule
